// File: rtl/stream_arb2.sv
// Two-source round-robin packet arbiter with packet-locked grant,
// beat-limit release and one registered valid/ready output stage.
module stream_arb2 #(
  parameter int W         = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  input  logic         b_last,
  output logic         b_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         sel,
  output logic         err_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_A,
    GRANT_B
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             sel_q, sel_d;
  logic             err_q, err_d;

  logic             room;
  logic             g_valid;
  logic [W-1:0]     g_data;
  logic             g_last;
  logic             g_src;
  logic             xfer;
  logic [CNT_W-1:0] cnt_nxt;

  // The output register may take a new beat when empty or draining.
  assign room = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sel_d       = sel_q;
    err_d       = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    g_valid     = 1'b0;
    g_data      = '0;
    g_last      = 1'b0;
    g_src       = 1'b0;
    xfer        = 1'b0;
    cnt_nxt     = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (a_valid && (!b_valid || !prio_q)) begin
          state_d = GRANT_A;
        end else if (b_valid) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        a_ready = room;
        g_valid = a_valid;
        g_data  = a_data;
        g_last  = a_last;
        g_src   = 1'b0;
      end
      GRANT_B: begin
        b_ready = room;
        g_valid = b_valid;
        g_data  = b_data;
        g_last  = b_last;
        g_src   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    xfer = g_valid && room;

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = g_data;
      out_last_d  = g_last;
      sel_d       = g_src;
      if (g_last) begin
        state_d = IDLE;
        prio_d  = !g_src;
        cnt_d   = '0;
      end else if (cnt_nxt == MAX_CNT) begin
        // Forced release: source never signalled last in time.
        state_d = IDLE;
        prio_d  = !g_src;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_nxt;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sel_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign sel         = sel_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Bench for stream_arb2: directed packet scenarios plus randomized
// traffic checked by per-source scoreboards and packet rules.
module tb_stream_arb2;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       sel, err_overrun;

  stream_arb2 #(.W(8), .MAX_BEATS(MAXB), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sel(sel), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int pv, pr;
  int rdy_lo_from, rdy_lo_to, a_off_from, a_off_to;
  int err_cnt, exp_err, run_len;
  logic run_src;
  bit a_acc, b_acc, hold_p;
  logic [9:0] hold_v;

  // Source queues and expected-beat queues hold {last, data}.
  logic [8:0] qa[$], qb[$], exp_a[$], exp_b[$];
  // Logged output beats hold {sel, last, data}.
  logic [9:0] log_beat[$], want[$];
  int log_cyc[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(string tag);
    chk({tag, "_n"}, log_beat.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      chk(tag, (i < log_beat.size()) ? 32'(log_beat[i]) : 32'hffffffff,
          32'(want[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 0; b_valid = 0; out_ready = 0;
    a_data = 0; b_data = 0; a_last = 0; b_last = 0;
    qa.delete(); qb.delete(); exp_a.delete(); exp_b.delete();
    log_beat.delete(); log_cyc.delete();
    a_acc = 0; b_acc = 0; hold_p = 0; run_len = 0; run_src = 0;
    err_cnt = 0; exp_err = 0;
    rdy_lo_from = -1; rdy_lo_to = -2; a_off_from = -1; a_off_to = -2;
    pv = 100; pr = 100;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cyc = -1;
  endtask

  task automatic cycle();
    logic [8:0] tmp;
    @(posedge clk); #1;
    cyc++;
    if (a_acc) tmp = qa.pop_front();
    if (b_acc) tmp = qb.pop_front();
    a_valid = (qa.size() != 0) && !(cyc >= a_off_from && cyc <= a_off_to)
              && ($urandom_range(99) < pv);
    if (qa.size() != 0) {a_last, a_data} = qa[0];
    b_valid = (qb.size() != 0) && ($urandom_range(99) < pv);
    if (qb.size() != 0) {b_last, b_data} = qb[0];
    out_ready = !(cyc >= rdy_lo_from && cyc <= rdy_lo_to)
                && ($urandom_range(99) < pr);
    @(negedge clk);
    if (hold_p)
      chk("hold", {out_valid, sel, out_last, out_data}, {1'b1, hold_v});
    hold_p = out_valid && !out_ready;
    hold_v = {sel, out_last, out_data};
    if (out_valid && !out_ready) chk("rdy_bp", a_ready | b_ready, 0);
    chk("rdy_excl", a_ready & b_ready, 0);
    if (err_overrun) err_cnt++;
    if (out_valid && out_ready) begin
      log_beat.push_back({sel, out_last, out_data});
      log_cyc.push_back(cyc);
      if (sel) begin
        if (exp_b.size() == 0) chk("sb_b_empty", 1, 0);
        else chk("sb_b", {out_last, out_data}, exp_b.pop_front());
      end else begin
        if (exp_a.size() == 0) chk("sb_a_empty", 1, 0);
        else chk("sb_a", {out_last, out_data}, exp_a.pop_front());
      end
      if (run_len > 0) chk("atomic", sel, run_src);
      run_src = sel;
      run_len++;
      if (out_last) run_len = 0;
      else if (run_len == MAXB) begin
        run_len = 0;
        exp_err++;
      end
    end
    a_acc = a_valid && a_ready;
    b_acc = b_valid && b_ready;
    if (a_acc) exp_a.push_back({a_last, a_data});
    if (b_acc) exp_b.push_back({b_last, b_data});
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_sel", sel, 0);
    chk("rst_err", err_overrun, 0);
    chk("rst_rdy", {a_ready, b_ready}, 0);

    // Single A packet, latency and timing
    qa = '{9'h011, 9'h122};
    cycle();
    chk("t1_rdy0", a_ready, 0);
    cycle();
    chk("t1_rdy1", a_ready, 1);
    repeat (4) cycle();
    want = '{10'h011, 10'h122};
    chk_log("t1_log");
    chk("t1_cyc0", log_cyc.size() > 0 ? log_cyc[0] : -1, 2);
    chk("t1_cyc1", log_cyc.size() > 1 ? log_cyc[1] : -1, 3);
    chk("t1_idle", {a_ready, out_valid}, 0);

    // Round robin with both sources valid from reset
    do_reset();
    qa = '{9'h0A0, 9'h1A1, 9'h1A2};
    qb = '{9'h0B0, 9'h1B1};
    repeat (12) cycle();
    want = '{10'h0A0, 10'h1A1, 10'h2B0, 10'h3B1, 10'h1A2};
    chk_log("t2_log");

    // Backpressure during an A packet
    do_reset();
    qa = '{9'h001, 9'h002, 9'h003, 9'h104};
    rdy_lo_from = 3; rdy_lo_to = 5;
    repeat (14) cycle();
    want = '{10'h001, 10'h002, 10'h003, 10'h104};
    chk_log("t3_log");

    // Overrun: B streams without last, A arrives later
    do_reset();
    qb = '{9'h0B0, 9'h0B1, 9'h0B2, 9'h0B3, 9'h0B4, 9'h0B5};
    repeat (2) cycle();
    qa = '{9'h0A0, 9'h1A1};
    repeat (16) cycle();
    want = '{10'h2B0, 10'h2B1, 10'h2B2, 10'h2B3,
             10'h0A0, 10'h1A1, 10'h2B4, 10'h2B5};
    chk_log("t4_log");
    chk("t4_err", err_cnt, 1);
    chk("t4_err_model", err_cnt, exp_err);

    // Granted A stalls mid-packet while B waits
    do_reset();
    qa = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h1C3};
    qb = '{9'h0D0, 9'h1D1};
    a_off_from = 3; a_off_to = 4;
    repeat (16) cycle();
    want = '{10'h0C0, 10'h0C1, 10'h0C2, 10'h1C3, 10'h2D0, 10'h3D1};
    chk_log("t5_log");

    // Reset in the middle of a B packet
    do_reset();
    qb = '{9'h0E0, 9'h0E1, 9'h1E2};
    repeat (3) cycle();
    chk("t6_pre_sel", {out_valid, sel}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_sel", sel, 0);
    chk("t6_data", {out_last, out_data}, 0);
    chk("t6_rdy", {a_ready, b_ready}, 0);
    do_reset();
    qa = '{9'h1F0};
    qb = '{9'h1F1};
    repeat (10) cycle();
    want = '{10'h1F0, 10'h3F1};
    chk_log("t6_log");

    // Randomized traffic
    do_reset();
    pv = 70; pr = 70;
    for (int n = 0; n < 1500; n++) begin
      if (qa.size() < 3 && $urandom_range(3) == 0) begin
        int len = $urandom_range(6, 1);
        for (int k = 0; k < len; k++)
          qa.push_back({k == len - 1, 8'($urandom)});
      end
      if (qb.size() < 3 && $urandom_range(3) == 0) begin
        int len = $urandom_range(6, 1);
        for (int k = 0; k < len; k++)
          qb.push_back({k == len - 1, 8'($urandom)});
      end
      cycle();
    end
    pv = 100; pr = 100;
    for (int n = 0; n < 400; n++) begin
      if (qa.size() == 0 && qb.size() == 0 && exp_a.size() == 0
          && exp_b.size() == 0 && !out_valid) break;
      cycle();
    end
    chk("rnd_drain", qa.size() + qb.size() + exp_a.size() + exp_b.size(), 0);
    chk("rnd_err", err_cnt, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
